zigbee_chip_spreader: RTL and testbench

- Downstream consumer of the symbol FIFO in TOP. Pops 4-bit data symbols and spreads each into the IEEE 802.15.4 (2.4 GHz) 32-chip PN sequence.
- Emits the chips serially, one chip per CLKS_PER_CHIP clocks, gapless across symbols while data is available.
- Feeds the later O-QPSK I/Q split stage.

---
 rtl/zigbee_pkg.sv | 19 +
 rtl/zigbee_pn_lut.sv | 21 ++
 rtl/zigbee_chip_spreader.sv | 138 +++++++++++++
 tb/tb_zigbee_chip_spreader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_pkg.sv
// Shared constants and types for the 802.15.4 2.4 GHz chip spreader and its
// receive-side counterpart.
package zigbee_pkg;

    localparam int CHIPS_PER_SYMBOL = 32;

    // Bit 31 is chip c0, the first chip on air.
    localparam logic [31:0] PN_SYM0     = 32'hD9C3_522E;
    localparam logic [31:0] PN_ODD_MASK = 32'h5555_5555;

    typedef logic [3:0]                  symbol_t;
    typedef logic [CHIPS_PER_SYMBOL-1:0] chip_word_t;

    typedef enum logic {
        ST_IDLE,
        ST_SPREAD
    } spread_state_e;

endpackage

// File: rtl/zigbee_pn_lut.sv
// Combinational 4-bit symbol to 32-chip PN word; also used by the RX correlator.
module zigbee_pn_lut
    import zigbee_pkg::*;
(
    input  logic [3:0]  i_symbol,
    output logic [31:0] o_chips
);

    logic [63:0] w_doubled;
    logic [4:0]  w_rot;
    logic [31:0] w_rotated;

    // Rotating right by 4k chips is a right shift of the doubled word, since c0 is the MSB.
    always_comb begin
        w_doubled = {PN_SYM0, PN_SYM0};
        w_rot     = {i_symbol[2:0], 2'b00};
        w_rotated = 32'(w_doubled >> w_rot);
        o_chips   = i_symbol[3] ? (w_rotated ^ PN_ODD_MASK) : w_rotated;
    end

endmodule

// File: rtl/zigbee_chip_spreader.sv
// Pops 4-bit symbols from the symbol FIFO and emits their 32-chip PN sequences
// serially, gapless while symbols keep arriving.
module zigbee_chip_spreader
    import zigbee_pkg::*;
#(
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inEnable,
    input  logic       inEmpty,
    input  logic [3:0] inData,
    output logic       outReadEnable,
    output logic       outChip,
    output logic       outChipValid,
    output logic       outChipStrobe,
    output logic [4:0] outChipIndex,
    output logic       outSymbolStart,
    output logic       outUnderrun,
    output logic       outBusy
);

    localparam int DIV_W = (CLKS_PER_CHIP > 1) ? $clog2(CLKS_PER_CHIP) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_CHIP - 1);

    spread_state_e r_state, w_stateNext;

    logic             r_readEn, r_rdPend, r_nextValid;
    logic [3:0]       r_nextSym;
    logic [31:0]      r_shift;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_idx;
    logic             r_chipValid, r_strobe, r_symStart, r_underrun;

    logic        w_load, w_underrun, w_divWrap, w_lastChip, w_fetch;
    logic [31:0] w_chips;

    zigbee_pn_lut u_lut (
        .i_symbol (r_nextSym),
        .o_chips  (w_chips)
    );

    assign w_divWrap  = (r_div == DIV_MAX);
    assign w_lastChip = w_divWrap && (r_idx == 5'(CHIPS_PER_SYMBOL - 1));
    // A read in flight counts as occupying the buffer, so only one is ever outstanding.
    assign w_fetch    = inEnable && !inEmpty && !r_nextValid && !r_readEn && !r_rdPend;

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) r_state <= ST_IDLE;
        else         r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_nextValid && inEnable) begin
                    w_load      = 1'b1;
                    w_stateNext = ST_SPREAD;
                end
            end
            ST_SPREAD: begin
                if (w_lastChip) begin
                    if (r_nextValid && inEnable) begin
                        w_load = 1'b1;
                    end else begin
                        w_stateNext = ST_IDLE;
                        w_underrun  = inEnable;
                    end
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            r_readEn    <= 1'b0;
            r_rdPend    <= 1'b0;
            r_nextValid <= 1'b0;
            r_nextSym   <= '0;
            r_shift     <= '0;
            r_div       <= '0;
            r_idx       <= '0;
            r_chipValid <= 1'b0;
            r_strobe    <= 1'b0;
            r_symStart  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_readEn   <= w_fetch;
            r_rdPend   <= r_readEn;
            r_strobe   <= 1'b0;
            r_symStart <= 1'b0;
            r_underrun <= w_underrun;
            if (r_rdPend) begin
                r_nextSym   <= inData;
                r_nextValid <= 1'b1;
            end else if (w_load) begin
                r_nextValid <= 1'b0;
            end
            if (w_load) begin
                r_shift     <= w_chips;
                r_idx       <= '0;
                r_div       <= '0;
                r_chipValid <= 1'b1;
                r_strobe    <= 1'b1;
                r_symStart  <= 1'b1;
            end else if (r_state == ST_SPREAD) begin
                if (w_lastChip) begin
                    // Clearing the shifter keeps outChip at 0 while idle.
                    r_shift     <= '0;
                    r_idx       <= '0;
                    r_div       <= '0;
                    r_chipValid <= 1'b0;
                end else if (w_divWrap) begin
                    r_shift  <= {r_shift[30:0], 1'b0};
                    r_idx    <= r_idx + 5'd1;
                    r_div    <= '0;
                    r_strobe <= 1'b1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign outReadEnable  = r_readEn;
    assign outChip        = r_shift[31];
    assign outChipValid   = r_chipValid;
    assign outChipStrobe  = r_strobe;
    assign outChipIndex   = r_idx;
    assign outSymbolStart = r_symStart;
    assign outUnderrun    = r_underrun;
    assign outBusy        = (r_state != ST_IDLE) || r_readEn || r_rdPend || r_nextValid;

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Directed and randomized bench for zigbee_chip_spreader with a FIFO model and
// a chip-index based PN reference.
module tb_zigbee_chip_spreader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;
    logic empty1, rd1, chip1, vld1, stb1, ss1, und1, busy1;
    logic empty2, rd2, chip2, vld2, stb2, ss2, und2, busy2;
    logic [3:0] data1, data2;
    logic [4:0] idx1, idx2;

    zigbee_chip_spreader #(.CLKS_PER_CHIP(1)) dut1 (
        .inClock(clk), .inReset(rst), .inEnable(en), .inEmpty(empty1), .inData(data1),
        .outReadEnable(rd1), .outChip(chip1), .outChipValid(vld1), .outChipStrobe(stb1),
        .outChipIndex(idx1), .outSymbolStart(ss1), .outUnderrun(und1), .outBusy(busy1));

    zigbee_chip_spreader #(.CLKS_PER_CHIP(4)) dut2 (
        .inClock(clk), .inReset(rst), .inEnable(en), .inEmpty(empty2), .inData(data2),
        .outReadEnable(rd2), .outChip(chip2), .outChipValid(vld2), .outChipStrobe(stb2),
        .outChipIndex(idx2), .outSymbolStart(ss2), .outUnderrun(und2), .outBusy(busy2));

    // FIFO models: data is valid the clock after a sampled read enable.
    logic [3:0] mem1 [0:63];
    logic [3:0] mem2 [0:63];
    int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
    assign empty1 = (wp1 == rp1);
    assign empty2 = (wp2 == rp2);
    always @(posedge clk) begin
        if (rd1) begin data1 <= mem1[rp1 % 64]; rp1 <= rp1 + 1; end
        if (rd2) begin data2 <= mem2[rp2 % 64]; rp2 <= rp2 + 1; end
    end

    typedef struct packed {
        logic rd, chip, vld, stb;
        logic [4:0] idx;
        logic ss, und, busy;
    } rec_t;
    rec_t lg1[$];
    rec_t lg2[$];
    int rdempty = 0;

    always @(negedge clk) begin
        lg1.push_back('{rd1, chip1, vld1, stb1, idx1, ss1, und1, busy1});
        lg2.push_back('{rd2, chip2, vld2, stb2, idx2, ss2, und2, busy2});
        if ((rd1 && empty1) || (rd2 && empty2)) rdempty++;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [3:0] s);
        mem1[wp1 % 64] = s; wp1++;
    endtask

    task automatic push2(input logic [3:0] s);
        mem2[wp2 % 64] = s; wp2++;
    endtask

    function automatic rec_t get(input int w, input int i);
        return (w == 1) ? lg1[i] : lg2[i];
    endfunction

    function automatic int logsize(input int w);
        return (w == 1) ? lg1.size() : lg2.size();
    endfunction

    function automatic int count_rd(input int w, input int a, input int b);
        int n = 0;
        for (int i = a; i < b && i < logsize(w); i++) if (get(w, i).rd) n++;
        return n;
    endfunction

    // Reference: chip i of symbol s is sym0 chip (i-4k) mod 32, odd chips flipped for s>=8.
    function automatic logic [31:0] model_word(input int s);
        logic [31:0] c0 = 32'hD9C3522E;
        logic [31:0] w;
        int src;
        logic b;
        for (int i = 0; i < 32; i++) begin
            src = (i - 4 * (s % 8) + 32) % 32;
            b = c0[31 - src];
            if (s >= 8 && (i % 2) == 1) b = ~b;
            w[31 - i] = b;
        end
        return w;
    endfunction

    task automatic chk_stream(input string tag, input int w, input int base, input int cpc,
                              input logic [31:0] words[$], input bit chk_lat,
                              input bit exp_und, input int exp_rd);
        int n, len, v0, r0, sz, bad;
        rec_t r;
        logic [31:0] obs;
        logic e_chip;
        n = words.size();
        len = 32 * n * cpc;
        sz = logsize(w);
        v0 = -1;
        for (int i = base; i < sz; i++) if (get(w, i).vld && v0 < 0) v0 = i;
        chk($sformatf("%s_start", tag), 64'(v0 >= 0 && v0 + len < sz), 64'd1);
        if (!(v0 >= 0 && v0 + len < sz)) return;
        if (chk_lat) begin
            r0 = -1;
            for (int i = base; i <= v0; i++) if (get(w, i).rd && r0 < 0) r0 = i;
            chk($sformatf("%s_latency", tag), 64'(v0 - r0), 64'd3);
        end
        for (int s = 0; s < n; s++) begin
            obs = '0;
            for (int c = 0; c < 32; c++) obs[31 - c] = get(w, v0 + (s * 32 + c) * cpc).chip;
            chk($sformatf("%s_word%0d", tag, s), 64'(obs), 64'(words[s]));
        end
        bad = 0;
        for (int j = 0; j < len; j++) begin
            r = get(w, v0 + j);
            e_chip = words[j / (32 * cpc)][31 - ((j / cpc) % 32)];
            if (r.vld !== 1'b1 || r.chip !== e_chip || r.idx !== 5'((j / cpc) % 32) ||
                r.stb !== ((j % cpc) == 0) || r.ss !== ((j % (32 * cpc)) == 0) || r.und !== 1'b0)
                bad++;
        end
        chk($sformatf("%s_ctrl_bad_cycles", tag), 64'(bad), 64'd0);
        r = get(w, v0 + len);
        chk($sformatf("%s_end_vld_chip_und", tag), 64'({r.vld, r.chip, r.und}), 64'({2'b00, exp_und}));
        if (exp_rd >= 0)
            chk($sformatf("%s_reads", tag), 64'(count_rd(w, base, v0 + len + 1)), 64'(exp_rd));
    endtask

    initial begin
        int base, drop_idx, t, nv;
        logic [3:0] s0, s1, s2, s3;
        logic [31:0] words[$];

        rst = 1'b1; en = 1'b0;
        tick(3);
        chk("reset_dut1", 64'({rd1, chip1, vld1, stb1, idx1, ss1, und1, busy1}), 64'd0);
        chk("reset_dut2", 64'({rd2, chip2, vld2, stb2, idx2, ss2, und2, busy2}), 64'd0);
        rst = 1'b0; en = 1'b1;
        tick(2);

        base = lg1.size(); push1(4'h0); tick(50);
        words = '{32'hD9C3522E};
        chk_stream("sym0", 1, base, 1, words, 1, 1, 1);

        base = lg1.size(); push1(4'h8); tick(50);
        words = '{32'h8C96077B};
        chk_stream("sym8", 1, base, 1, words, 1, 1, 1);

        base = lg1.size(); push1(4'h1); tick(50);
        words = '{32'hED9C3522};
        chk_stream("sym1", 1, base, 1, words, 1, 1, 1);

        base = lg1.size(); push1(4'h0); push1(4'hD); tick(90);
        words = '{32'hD9C3522E, model_word(13)};
        chk_stream("b2b", 1, base, 1, words, 1, 1, 2);

        s0 = 4'($urandom); s1 = 4'($urandom); s2 = 4'($urandom); s3 = 4'($urandom);
        base = lg1.size(); push1(s0); push1(s1); push1(s2); push1(s3); tick(150);
        words = '{model_word(s0), model_word(s1), model_word(s2), model_word(s3)};
        chk_stream("rand4", 1, base, 1, words, 1, 1, 4);

        base = lg2.size(); push2(4'h3); tick(150);
        words = '{model_word(3)};
        chk_stream("cpc4", 2, base, 4, words, 1, 1, 1);

        s0 = 4'($urandom); s1 = 4'($urandom); s2 = 4'($urandom);
        base = lg1.size(); push1(s0); push1(s1); push1(s2);
        t = 0;
        while (!vld1 && t < 20) begin tick(1); t++; end
        tick(10);
        en = 1'b0;
        drop_idx = lg1.size();
        tick(40);
        words = '{model_word(s0)};
        chk_stream("en_drop", 1, base, 1, words, 1, 0, 2);
        chk("en_drop_no_reads", 64'(count_rd(1, drop_idx, lg1.size())), 64'd0);
        base = lg1.size(); en = 1'b1; tick(90);
        words = '{model_word(s1), model_word(s2)};
        chk_stream("en_resume", 1, base, 1, words, 0, 1, 1);

        base = lg1.size(); tick(40);
        chk("empty_no_reads", 64'(count_rd(1, base, lg1.size())), 64'd0);
        chk("empty_idle_busy", 64'(busy1), 64'd0);

        s0 = 4'($urandom); s1 = 4'($urandom); s2 = 4'($urandom);
        push1(s0); push1(s1);
        t = 0;
        while (!vld1 && t < 20) begin tick(1); t++; end
        tick(17);
        rst = 1'b1; #1;
        chk("rst_async_outputs", 64'({rd1, chip1, vld1, stb1, idx1, ss1, und1, busy1}), 64'd0);
        tick(2);
        rst = 1'b0;
        base = lg1.size();
        tick(5);
        nv = 0;
        for (int i = base; i < lg1.size(); i++) if (lg1[i].vld) nv++;
        chk("rst_prefetch_dropped", 64'(nv), 64'd0);
        push1(s2); tick(50);
        words = '{model_word(s2)};
        chk_stream("post_rst", 1, base, 1, words, 1, 1, 1);

        chk("no_read_when_empty", 64'(rdempty), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
